// File: rtl/meta_selector_table.sv
// rtl/meta_selector_table.sv - per-class confidence table arbitrating component branch predictors (optional META_SELECTOR_AGING_EN row aging)
module meta_selector_table #(
    parameter int NUM_PRED  = 3,
    parameter int NUM_CLASS = 6,
    parameter int IDX_W     = 2,
    parameter int CONF_W    = 5,
    parameter int CONF_INIT = 8,
    parameter int CLASS_W   = $clog2(NUM_CLASS),
    parameter int SEL_W     = $clog2(NUM_PRED)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      lk_valid,
    input  logic [CLASS_W-1:0]        lk_class,
    input  logic [NUM_PRED*IDX_W-1:0] lk_idx,
    input  logic [NUM_PRED-1:0]       lk_pred,
    output logic                      pred_valid,
    output logic                      pred_taken,
    output logic [SEL_W-1:0]          pred_sel,
    input  logic                      upd_valid,
    input  logic [CLASS_W-1:0]        upd_class,
    input  logic [NUM_PRED*IDX_W-1:0] upd_idx,
    input  logic [NUM_PRED-1:0]       upd_pred,
    input  logic                      upd_taken,
    output logic                      init_busy
);

    localparam int DEPTH    = 1 << IDX_W;
    localparam int NUM_ROWS = NUM_CLASS << IDX_W;
    localparam int PTR_W    = CLASS_W + IDX_W;
    localparam logic [CONF_W-1:0]  CONF_MAX  = {CONF_W{1'b1}};
    localparam logic [CONF_W-1:0]  CONF_RST  = CONF_W'(CONF_INIT);
    localparam logic [PTR_W-1:0]   LAST_ROW  = PTR_W'(NUM_ROWS - 1);
    localparam logic [CLASS_W:0]   CLASS_LIM = (CLASS_W + 1)'(NUM_CLASS);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   init_ptr_q, init_ptr_d;
    logic               init_busy_q, init_busy_d;
    logic               pred_valid_q, pred_valid_d;
    logic               pred_taken_q, pred_taken_d;
    logic [SEL_W-1:0]   pred_sel_q, pred_sel_d;
    logic [CONF_W-1:0]  conf_q [NUM_PRED][NUM_CLASS][DEPTH];
    logic [CONF_W-1:0]  conf_d [NUM_PRED][NUM_CLASS][DEPTH];

    logic               lk_ok, upd_ok;
    logic [CLASS_W-1:0] lk_cls, upd_cls;
    logic [CONF_W-1:0]  best_val;
    logic [SEL_W-1:0]   best_sel;
    logic [IDX_W-1:0]   upd_i;
    logic [CONF_W-1:0]  cur;
    logic [DEPTH-1:0]   row_age;

    assign lk_ok   = ({1'b0, lk_class} < CLASS_LIM);
    assign upd_ok  = ({1'b0, upd_class} < CLASS_LIM);
    assign lk_cls  = lk_ok ? lk_class : '0;
    assign upd_cls = upd_ok ? upd_class : '0;

    // Most confident predictor for the lookup row; strict compare keeps the lowest index on ties
    always_comb begin
        best_val = conf_q[0][lk_cls][lk_idx[0 +: IDX_W]];
        best_sel = '0;
        for (int p = 1; p < NUM_PRED; p++) begin
            if (conf_q[p][lk_cls][lk_idx[p*IDX_W +: IDX_W]] > best_val) begin
                best_val = conf_q[p][lk_cls][lk_idx[p*IDX_W +: IDX_W]];
                best_sel = SEL_W'(p);
            end
        end
    end

    // Init sweep sequencing and registered lookup result (flush > stall > lookup)
    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        init_busy_d  = init_busy_q;
        pred_valid_d = pred_valid_q;
        pred_taken_d = pred_taken_q;
        pred_sel_d   = pred_sel_q;
        if (state_q == ST_INIT) begin
            pred_valid_d = 1'b0;
            if (init_ptr_q == LAST_ROW) begin
                state_d     = ST_RUN;
                init_busy_d = 1'b0;
                init_ptr_d  = '0;
            end else begin
                init_ptr_d = init_ptr_q + 1'b1;
            end
        end else if (flush) begin
            pred_valid_d = 1'b0;
        end else if (!stall) begin
            if (lk_valid && lk_ok) begin
                pred_valid_d = 1'b1;
                pred_sel_d   = best_sel;
                pred_taken_d = lk_pred[best_sel];
            end else begin
                pred_valid_d = 1'b0;
            end
        end
    end

    // Table writes: init sweep fills a row per cycle, otherwise train every predictor on resolution
    always_comb begin
        conf_d  = conf_q;
        row_age = '0;
        upd_i   = '0;
        cur     = '0;
        if (state_q == ST_INIT) begin
            for (int p = 0; p < NUM_PRED; p++) begin
                conf_d[p][init_ptr_q[PTR_W-1:IDX_W]][init_ptr_q[IDX_W-1:0]] = CONF_RST;
            end
        end else if (upd_valid && upd_ok) begin
            for (int p = 0; p < NUM_PRED; p++) begin
                upd_i = upd_idx[p*IDX_W +: IDX_W];
                cur   = conf_q[p][upd_cls][upd_i];
                if (upd_pred[p] == upd_taken) begin
                    if (cur != CONF_MAX) begin
                        conf_d[p][upd_cls][upd_i] = cur + 1'b1;
                    end else begin
                        row_age[upd_i] = 1'b1;
                    end
                end else if (cur != '0) begin
                    conf_d[p][upd_cls][upd_i] = cur - 1'b1;
                end
            end
`ifdef META_SELECTOR_AGING_EN
            // A saturating hit halves its whole row after the individual steps
            for (int i = 0; i < DEPTH; i++) begin
                if (row_age[i]) begin
                    for (int q = 0; q < NUM_PRED; q++) begin
                        conf_d[q][upd_cls][i] = conf_d[q][upd_cls][i] >> 1;
                    end
                end
            end
`endif
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            init_busy_q  <= 1'b1;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_sel_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            init_busy_q  <= init_busy_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_sel_q   <= pred_sel_d;
        end
    end

    // Confidence storage; contents are rebuilt by the init sweep so no reset is needed
    always_ff @(posedge clk) begin
        conf_q <= conf_d;
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_sel   = pred_sel_q;
    assign init_busy  = init_busy_q;

endmodule

// File: tb/tb_meta_selector_table.sv
// tb/tb_meta_selector_table.sv - self-checking bench for meta_selector_table against a table model
module tb_meta_selector_table;

    localparam int NP = 3;
    localparam int NC = 6;
    localparam int IW = 2;
    localparam int CMAX = 31;
    localparam int CINIT = 8;
    localparam int ROWS = 24;

    logic          clk = 1'b0;
    logic          rst, stall, flush, lk_valid, upd_valid, upd_taken;
    logic [2:0]    lk_class, upd_class;
    logic [5:0]    lk_idx, upd_idx;
    logic [2:0]    lk_pred, upd_pred;
    logic          pred_valid, pred_taken, init_busy;
    logic [1:0]    pred_sel;

    int checks = 0;
    int errors = 0;

    meta_selector_table dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .lk_valid(lk_valid), .lk_class(lk_class), .lk_idx(lk_idx), .lk_pred(lk_pred),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_sel(pred_sel),
        .upd_valid(upd_valid), .upd_class(upd_class), .upd_idx(upd_idx),
        .upd_pred(upd_pred), .upd_taken(upd_taken), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: the table as plain integers plus expected outputs
    int  m [NP][NC][4];
    int  busy_left;
    bit  started = 0;
    int  ev, et, es;
    int  best, bsel, ii, cc;
    int  nv [NP];
    bit  aged [4];

    always @(posedge clk) begin
        if (rst) begin
            started   = 1;
            busy_left = ROWS;
            ev = 0; et = 0; es = 0;
            foreach (m[p, c, i]) m[p][c][i] = CINIT;
        end else if (started && busy_left > 0) begin
            busy_left--;
        end else if (started) begin
            if (flush) ev = 0;
            else if (!stall) begin
                if (lk_valid && lk_class < NC) begin
                    best = -1;
                    for (int p = 0; p < NP; p++) begin
                        if (m[p][lk_class][lk_idx[p*IW +: IW]] > best) begin
                            best = m[p][lk_class][lk_idx[p*IW +: IW]];
                            bsel = p;
                        end
                    end
                    ev = 1; es = bsel; et = lk_pred[bsel];
                end else ev = 0;
            end
            if (upd_valid && upd_class < NC) begin
                for (int i = 0; i < 4; i++) aged[i] = 0;
                for (int p = 0; p < NP; p++) begin
                    ii = upd_idx[p*IW +: IW];
                    cc = m[p][upd_class][ii];
                    if (upd_pred[p] == upd_taken) begin
                        if (cc == CMAX) aged[ii] = 1;
                        nv[p] = (cc + 1 > CMAX) ? CMAX : cc + 1;
                    end else nv[p] = (cc - 1 < 0) ? 0 : cc - 1;
                end
                for (int p = 0; p < NP; p++) m[p][upd_class][upd_idx[p*IW +: IW]] = nv[p];
`ifdef META_SELECTOR_AGING_EN
                for (int i = 0; i < 4; i++)
                    if (aged[i])
                        for (int q = 0; q < NP; q++) m[q][upd_class][i] = m[q][upd_class][i] / 2;
`endif
            end
        end
    end

    // Compare every cycle once reset has been applied
    always @(negedge clk) begin
        if (started) begin
            chk("init_busy", init_busy, busy_left > 0);
            chk("pred_valid", pred_valid, ev);
            chk("pred_sel", pred_sel, es);
            chk("pred_taken", pred_taken, et);
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_lk(input logic v, input logic [2:0] c, input logic [5:0] ix, input logic [2:0] pr);
        lk_valid = v; lk_class = c; lk_idx = ix; lk_pred = pr;
    endtask

    task automatic set_upd(input logic v, input logic [2:0] c, input logic [5:0] ix, input logic [2:0] pr, input logic t);
        upd_valid = v; upd_class = c; upd_idx = ix; upd_pred = pr; upd_taken = t;
    endtask

    // Count cycles with init_busy high, bounded
    task automatic count_init(output int n);
        int guard;
        n = 0;
        guard = 0;
        while (init_busy && guard < 200) begin
            n++;
            guard++;
            step();
        end
        if (guard >= 200) chk("init_timeout", guard, 0);
    endtask

    int n;

    initial begin
        rst = 0; stall = 0; flush = 0;
        set_lk(1, 0, 0, 3'b010);
        set_upd(0, 0, 0, 0, 0);
        step();
        rst = 1; step(); rst = 0;

        // 1: init sweep length with lookups pending
        count_init(n);
        chk("init_len", n, 24);

        // 2: tie at CONF_INIT resolves to predictor 0
        step();
        chk("s2_valid", pred_valid, 1);
        chk("s2_sel", pred_sel, 0);
        chk("s2_taken", pred_taken, 0);

        // 3: train p1 three times
        set_lk(0, 0, 0, 3'b010);
        set_upd(1, 0, 0, 3'b010, 1);
        step(3);
        set_upd(0, 0, 0, 0, 0);
        chk("s3_m_p1", m[1][0][0], 11);
        chk("s3_m_p0", m[0][0][0], 5);
        chk("s3_m_p2", m[2][0][0], 5);
        set_lk(1, 0, 0, 3'b010);
        step();
        chk("s3_sel", pred_sel, 1);
        chk("s3_taken", pred_taken, 1);

        // same-edge lookup sees pre-update table
        set_lk(1, 1, 0, 3'b010);
        set_upd(1, 1, 0, 3'b010, 1);
        step();
        chk("pre_upd_sel", pred_sel, 0);
        set_upd(0, 0, 0, 0, 0);
        step();
        chk("post_upd_sel", pred_sel, 1);

        // 4: saturation at both ends
        set_lk(1, 0, 0, 3'b010);
        set_upd(1, 0, 0, 3'b010, 1);
        step(40);
        set_upd(0, 0, 0, 0, 0);
`ifndef META_SELECTOR_AGING_EN
        chk("s4_m_p1", m[1][0][0], 31);
        chk("s4_m_p0", m[0][0][0], 0);
        chk("s4_m_p2", m[2][0][0], 0);
`endif
        step();
        chk("s4_sel", pred_sel, 1);

        // 5: stall holds, flush kills, bad class drops valid
        set_lk(1, 2, 0, 3'b001);
        stall = 1; step();
        chk("s5_stall_valid", pred_valid, 1);
        chk("s5_stall_sel", pred_sel, 1);
        stall = 0; flush = 1; step();
        chk("s5_flush_valid", pred_valid, 0);
        flush = 0; step();
        chk("s5_c2_sel", pred_sel, 0);
        chk("s5_c2_taken", pred_taken, 1);
        set_lk(1, 6, 0, 3'b010); step();
        chk("s5_badcls_valid", pred_valid, 0);
        chk("s5_badcls_sel", pred_sel, 0);
        set_lk(1, 2, 0, 3'b001); step();
        stall = 1; flush = 1; step();
        chk("s5_flush_stall", pred_valid, 0);
        stall = 0; flush = 0;

        // distinct per-predictor indices
        set_lk(0, 3, 0, 3'b100);
        set_upd(1, 3, {2'd3, 2'd1, 2'd2}, 3'b100, 1);
        step();
        set_upd(0, 0, 0, 0, 0);
        chk("idx_m_p2", m[2][3][3], 9);
        chk("idx_m_p1", m[1][3][1], 7);
        set_lk(1, 3, {2'd3, 2'd1, 2'd2}, 3'b100); step();
        chk("idx_sel", pred_sel, 2);
        set_lk(1, 3, 0, 3'b100); step();
        chk("idx_zero_sel", pred_sel, 0);

        // reset in the middle of the sweep restarts it
        rst = 1; step(); rst = 0;
        step(9);
        rst = 1; step(); rst = 0;
        count_init(n);
        chk("reinit_len", n, 24);

`ifdef META_SELECTOR_AGING_EN
        // 6: aging halves the row on a saturating hit
        set_lk(0, 0, 0, 3'b010);
        set_upd(1, 0, 0, 3'b010, 1); step(19);
        set_upd(1, 0, 0, 3'b110, 1); step(4);
        set_upd(0, 0, 0, 0, 0);
        chk("s6_pre_p1", m[1][0][0], 31);
        chk("s6_pre_p0", m[0][0][0], 0);
        chk("s6_pre_p2", m[2][0][0], 4);
        set_upd(1, 0, 0, 3'b010, 1); step();
        set_upd(0, 0, 0, 0, 0);
        chk("s6_p1", m[1][0][0], 15);
        chk("s6_p0", m[0][0][0], 0);
        chk("s6_p2", m[2][0][0], 1);
        set_lk(1, 0, 0, 3'b010); step();
        chk("s6_sel", pred_sel, 1);
`endif

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/meta_selector_table.md
Name: meta_selector_table

Overview:
- Parametrised successor of the fixed six-class, three-predictor meta predictor.
- Tracks a saturating confidence counter per (component predictor, branch class, predictor index).
- Picks the most-confident component for each lookup, with a registered result; trains all components at branch resolution.
- Sits between the component predictors (SP/LHP/GHP and others) and the fetch-stage redirect logic; initialises its own table after reset.

Parameters:
NUM_PRED, 3, number of component predictors arbitrated
NUM_CLASS, 6, number of branch classes (beq..bgeu)
IDX_W, 2, per-predictor index width (e.g. jump-status counter value)
CONF_W, 5, confidence counter width
CONF_INIT, 8, counter value written during init sweep
CLASS_W, $clog2(NUM_CLASS), derived
SEL_W, $clog2(NUM_PRED), derived

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  pipeline stall; holds lookup outputs
flush  in  1  kill pending lookup result
lk_valid  in  1  lookup request
lk_class  in  CLASS_W  branch class of lookup
lk_idx  in  NUM_PRED*IDX_W  per-predictor index, predictor p at [p*IDX_W +: IDX_W]
lk_pred  in  NUM_PRED  component predictions, bit p = predictor p
pred_valid  out  1  registered result valid
pred_taken  out  1  selected prediction
pred_sel  out  SEL_W  selected predictor number
upd_valid  in  1  resolution update
upd_class  in  CLASS_W  class of resolved branch
upd_idx  in  NUM_PRED*IDX_W  indices captured at lookup
upd_pred  in  NUM_PRED  component predictions captured at lookup
upd_taken  in  1  actual outcome
init_busy  out  1  table initialisation in progress

Behaviour:
- Storage: conf[p][c][i], CONF_W bits each, NUM_PRED*NUM_CLASS*2^IDX_W entries.
- Reset (rst=1 at posedge): state=INIT, init_ptr=0, pred_valid=0, pred_taken=0, pred_sel=0, init_busy=1. Reset asserted at any time, including mid-sweep, restarts INIT.
- INIT: each cycle writes CONF_INIT to conf[all p][init_ptr.class][init_ptr.idx]. init_ptr steps idx first, then class.
  - The sweep takes NUM_CLASS<<IDX_W cycles. After the last row, state=RUN and init_busy=0 on the next edge.
  - lk_*, upd_*, stall and flush are ignored in INIT; pred_valid stays 0.
- RUN lookup (latency 1):
  - On a posedge with lk_valid=1, stall=0, flush=0 and lk_class<NUM_CLASS:
    - pred_valid<=1.
    - pred_sel<=argmax over p of conf[p][lk_class][lk_idx_p]; on a tie, the lowest p wins.
    - pred_taken<=lk_pred[pred_sel].
  - lk_valid=0 or lk_class>=NUM_CLASS, with stall=0: pred_valid<=0; pred_sel and pred_taken hold.
  - stall=1 and flush=0: all outputs hold.
  - flush=1: pred_valid<=0 regardless of stall or lk_valid. Priority is flush > stall > lookup.
- RUN update (not gated by stall or flush; ignored when upd_class>=NUM_CLASS):
  - For each p: if upd_pred[p]==upd_taken, conf[p][upd_class][upd_idx_p] +1, saturating at 2^CONF_W-1; otherwise -1, saturating at 0.
  - All NUM_PRED counters update on the same edge.
- Same-cycle lookup and update of the same entry: the lookup reads the pre-update value. There is no forwarding.
- Arithmetic: unsigned, CONF_W bits. Saturation is checked before the write, so there is no wrap-around.

Optional Feature:
- Macro META_SELECTOR_AGING_EN.
- Defined:
  - When an update's increment would exceed max (counter already at 2^CONF_W-1), every counter in that row (conf[all p][upd_class][row idx of the saturating p]) is shifted right by 1 on that edge.
  - The shift is applied after each counter's own ±1 step; the saturating counter takes max>>1.
  - Non-saturating updates behave as in the base design.
- Undefined: plain saturation; no aging logic is synthesised.

Test Plan:
1. Reset pulse 1 cycle, then lk_valid=1 every cycle (defaults) -> init_busy=1 for exactly 24 cycles; pred_valid=0 throughout; first pred_valid=1 on the cycle after init_busy falls plus 1.
2. Post-init lookup class 0, all idx 0, lk_pred=3'b010 -> next cycle pred_valid=1, pred_sel=0 (tie at 8), pred_taken=0.
3. Three updates class 0, idx 0, upd_pred=3'b010, upd_taken=1 -> conf p1=11, p0=p2=5; lookup lk_pred=3'b010 -> pred_sel=1, pred_taken=1.
4. 40 identical updates as in scenario 3 (aging off) -> p1 holds 31, p0/p2 hold 0, no wrap; simultaneous lookup on the update edge returns the pre-update selection.
5. Lookup issued with stall=1 -> pred_* hold previous values; lk_valid=1 with flush=1 -> pred_valid=0 next cycle; rst asserted mid-INIT at cycle 10 -> init_busy stays 1 for 24 more cycles.
6. Aging on: p1=31, p0=0, p2=4 in row; correct-for-p1-only update -> p1=15, p0=0, p2=1.
